pipe_stage_fifo: RTL

- Parametrised successor to the fixed single-entry stall/flush pipeline registers between pipeline stages (fetch→decode, decode→renaming, etc.).
- Holds up to DEPTH multi-lane bundles in a circular buffer with a valid/ready handshake, so an upstream stage keeps running while the downstream stage stalls.
- Flush discards every buffered bundle in one cycle. Intended drop-in for dreg/rreg/ireg, with LANES = MACHINE_WIDTH.

---
 rtl/pipe_stage_fifo_if.sv | 16 +
 rtl/pipe_stage_fifo.sv | 107 ++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo_if.sv
// Valid/ready bundle handshake between pipeline stages.
//   valid : per-lane valid of the bundle offered by the master
//   data  : lane payloads, lane i at [i*DATA_W +: DATA_W]
//   ready : the slave accepts the offered bundle this cycle
// The master modport drives valid/data and the slave modport drives ready.
interface pipe_stage_fifo_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 2
);
  logic [LANES-1:0]        valid;
  logic [LANES*DATA_W-1:0] data;
  logic                    ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_fifo.sv
// Multi-lane pipeline-stage FIFO. Buffers up to DEPTH bundles of LANES lanes
// in a circular buffer, so the upstream stage can keep running while the
// downstream stage stalls. A flush empties the buffer in a single cycle.
// Ports:
//   clk, resetn : clock (rising edge) and asynchronous active-low reset
//   flush       : discard all entries and drop any same-cycle push or pop
//   in_if       : upstream side (valid/data in, ready = !full out)
//   out_if      : downstream side (head valid/data out, ready = !stall in)
//   count       : number of buffered bundles
//   full, empty : count == DEPTH, count == 0
module pipe_stage_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  pipe_stage_fifo_if.slave    in_if,
  pipe_stage_fifo_if.master   out_if,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned BW   = LANES * DATA_W;

  logic [PtrW-1:0]                head_q, head_d;
  logic [PtrW-1:0]                tail_q, tail_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [DEPTH-1:0][LANES-1:0]    mask_q, mask_d;
  logic [DEPTH-1:0][BW-1:0]       data_q;

  logic offered, push, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Ready depends only on registered state: a full buffer refuses a push even
  // if the head is popped in the same cycle.
  assign in_if.ready = !full;

  assign offered = |in_if.valid;
  assign push    = offered && !full && !flush;
  assign pop     = !empty && out_if.ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mask_d  = mask_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      mask_d  = '0;
    end else begin
      if (push) begin
        mask_d[tail_q] = in_if.valid;
        tail_d         = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mask_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mask_q  <= mask_d;
    end
  end

  // Payload storage needs no reset: outputs are masked to zero while empty
  // and an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail_q] <= in_if.data;
    end
  end

  always_comb begin
    out_if.valid = '0;
    out_if.data  = '0;
    if (!empty) begin
      out_if.valid = mask_q[head_q];
      out_if.data  = data_q[head_q];
    end
  end

endmodule
